loop_counter_nested: RTL and testbench

Two-level down-counting loop index generator for the MAC datapath. It replaces single-level counter control with a start/done sequencer. One start pulse walks an inner index `i` from `ni` down to 1, once for each value of an outer index `j` from `no` down to 1. It emits one iteration beat per non-stalled cycle and exposes per-beat last flags for accumulator clear and write-back control.

---
 rtl/loop_counter_nested.sv | 119 +++++++++++
 tb/tb_loop_counter_nested.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/loop_counter_nested.sv
// Two-level down-counting loop index generator: one start walks i = ni..1 for each j = no..1.
// Optional abort port and behaviour are enabled with the LOOP_CNT_ABORT_EN macro.
//
// state | meaning
// IDLE  | waiting for start, indices and latched count cleared
// RUN   | emitting one (i,j) beat per non-stalled cycle
// DONE  | one-cycle completion pulse, then back to IDLE
module loop_counter_nested #(
    parameter int WI = 6,
    parameter int WO = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [WI-1:0] ni_i,
    input  logic [WO-1:0] no_i,
    input  logic          stall_i,
`ifdef LOOP_CNT_ABORT_EN
    input  logic          abort_i,
`endif
    output logic          busy_o,
    output logic          valid_o,
    output logic [WI-1:0] i_o,
    output logic [WO-1:0] j_o,
    output logic          last_i_o,
    output logic          last_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [WI-1:0] i_q;
    logic [WO-1:0] j_q;
    logic [WI-1:0] nil;
    logic          i_one;
    logic          j_one;
    logic          in_run;
    logic          beat;
    logic          abort;

`ifdef LOOP_CNT_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign i_one  = (i_q == WI'(1));
    assign j_one  = (j_q == WO'(1));
    assign in_run = (state == RUN);
    assign beat   = in_run && !stall_i;

    // The outer count needs no separate copy: j is only ever decremented, never reloaded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            i_q   <= '0;
            j_q   <= '0;
            nil   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if ((ni_i != '0) && (no_i != '0)) begin
                            nil   <= ni_i;
                            i_q   <= ni_i;
                            j_q   <= no_i;
                            state <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        i_q   <= '0;
                        j_q   <= '0;
                        nil   <= '0;
                        state <= IDLE;
                    end else if (!stall_i) begin
                        if (!i_one) begin
                            i_q <= i_q - WI'(1);
                        end else if (!j_one) begin
                            i_q <= nil;
                            j_q <= j_q - WO'(1);
                        end else begin
                            i_q   <= '0;
                            j_q   <= '0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    nil   <= '0;
                    state <= IDLE;
                end
                default: begin
                    i_q   <= '0;
                    j_q   <= '0;
                    nil   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o   = (state != IDLE);
    assign done_o   = (state == DONE);
    assign valid_o  = beat;
    assign i_o      = i_q;
    assign j_o      = j_q;
    assign last_i_o = in_run && i_one;
    assign last_o   = in_run && i_one && j_one;

endmodule

// File: tb/tb_loop_counter_nested.sv
// Self-checking bench for loop_counter_nested: randomized runs checked against a queue of expected beats.
module tb_loop_counter_nested;

    localparam int WI = 6;
    localparam int WO = 6;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [WI-1:0] ni_i;
    logic [WO-1:0] no_i;
    logic          stall_i;
    logic          abort_i;
    logic          busy_o;
    logic          valid_o;
    logic [WI-1:0] i_o;
    logic [WO-1:0] j_o;
    logic          last_i_o;
    logic          last_o;
    logic          done_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int i;
        int j;
    } beat_t;

    beat_t exp_q[$];

    loop_counter_nested #(.WI(WI), .WO(WO)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .ni_i     (ni_i),
        .no_i     (no_i),
        .stall_i  (stall_i),
`ifdef LOOP_CNT_ABORT_EN
        .abort_i  (abort_i),
`endif
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .i_o      (i_o),
        .j_o      (j_o),
        .last_i_o (last_i_o),
        .last_o   (last_o),
        .done_o   (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_valid"}, int'(valid_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_i"}, int'(i_o), 0);
        chk({tag, "_j"}, int'(j_o), 0);
        chk({tag, "_last_i"}, int'(last_i_o), 0);
        chk({tag, "_last"}, int'(last_o), 0);
    endtask

    // Expected beat list in outer-major order, straight from the loop definition.
    task automatic build_model(input int ni, input int no);
        beat_t b;
        exp_q.delete();
        for (int j = no; j >= 1; j--)
            for (int i = ni; i >= 1; i--) begin
                b.i = i;
                b.j = j;
                exp_q.push_back(b);
            end
    endtask

    // Called at negedge+1 of an IDLE cycle; returns at negedge+1 of the following IDLE cycle.
    task automatic do_run(input int ni, input int no, input int pct,
                          input int st_lo, input int st_hi, input bit b2b);
        int cyc;
        int stalls;
        int beats;
        bit   s;
        build_model(ni, no);
        beats = exp_q.size();
        if (!b2b) begin
            @(negedge clk_i);
            #1;
        end
        start_i = 1'b1;
        ni_i    = WI'(ni);
        no_i    = WO'(no);
        stall_i = 1'b0;
        chk("pre_start_busy", int'(busy_o), 0);
        @(negedge clk_i);
        start_i = 1'b0;
        cyc     = 0;
        stalls  = 0;
        while (exp_q.size() > 0 && cyc < 20000) begin
            s       = ((cyc >= st_lo) && (cyc <= st_hi)) || (int'($urandom_range(99)) < pct);
            stall_i = s;
            start_i = 1'($urandom_range(1));
            ni_i    = WI'($urandom);
            no_i    = WO'($urandom);
            #1;
            chk("run_busy", int'(busy_o), 1);
            chk("run_done", int'(done_o), 0);
            chk("run_valid", int'(valid_o), s ? 0 : 1);
            chk("run_i", int'(i_o), exp_q[0].i);
            chk("run_j", int'(j_o), exp_q[0].j);
            chk("run_last_i", int'(last_i_o), (exp_q[0].i == 1) ? 1 : 0);
            chk("run_last", int'(last_o), (exp_q.size() == 1) ? 1 : 0);
            if (s) stalls++;
            else   void'(exp_q.pop_front());
            @(negedge clk_i);
            cyc++;
        end
        chk("run_no_timeout", exp_q.size(), 0);
        chk("run_length", cyc, beats + stalls);
        start_i = 1'b0;
        stall_i = 1'($urandom_range(1));
        #1;
        chk("done_pulse", int'(done_o), 1);
        chk("done_busy", int'(busy_o), 1);
        chk("done_valid", int'(valid_o), 0);
        @(negedge clk_i);
        #1;
        chk_idle("after_done");
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        ni_i    = '0;
        no_i    = '0;
        stall_i = 1'b0;
        abort_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk_idle("reset");
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk_idle("post_reset");

        do_run(3, 2, 0, -1, -1, 1'b0);   // basic: six beats, busy 7 cycles
        do_run(2, 2, 0, 1, 2, 1'b0);     // stall on RUN cycles 2-3, frozen at (1,2)
        do_run(0, 5, 0, -1, -1, 1'b0);   // zero length inner
        do_run(4, 0, 0, -1, -1, 1'b1);   // zero length outer, back-to-back start
        do_run(1, 1, 0, -1, -1, 1'b1);
        do_run(63, 63, 0, -1, -1, 1'b0); // maximum counts, no wrap
        for (int n = 0; n < 10; n++)
            do_run(int'($urandom_range(0, 7)), int'($urandom_range(0, 5)), 30, -1, -1,
                   1'($urandom_range(1)));

        // Reset mid-run: everything drops at once and no done pulse follows.
        @(negedge clk_i);
        start_i = 1'b1;
        ni_i    = 6'd5;
        no_i    = 6'd5;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        #1;
        chk("pre_rst_busy", int'(busy_o), 1);
        rst_i = 1'b1;
        #1;
        chk_idle("mid_rst");
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk_i);
            #1;
            chk("rst_no_done", int'(done_o), 0);
            chk("rst_no_busy", int'(busy_o), 0);
        end

`ifdef LOOP_CNT_ABORT_EN
        // Abort on beat 2 of a 3x2 run, then a fresh full run.
        @(negedge clk_i);
        start_i = 1'b1;
        ni_i    = 6'd3;
        no_i    = 6'd2;
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        chk("abort_beat1_i", int'(i_o), 3);
        @(negedge clk_i);
        abort_i = 1'b1;
        #1;
        chk("abort_beat2_i", int'(i_o), 2);
        @(negedge clk_i);
        abort_i = 1'b0;
        #1;
        chk_idle("after_abort");
        @(negedge clk_i);
        #1;
        chk("abort_no_done", int'(done_o), 0);
        do_run(3, 2, 0, -1, -1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
